// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset fetch address and the
// {pc, instruction} record that flows from fetch into the IF/ID buffer.
package cpu_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

    // Sequential successor of a word address; wraps at the top of the space.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a flush that wins over
// push and pop. Head entry is read straight out of the storage registers.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  cpu_pkg::fetch_entry_t push_data_i,
    input  logic                  pop_i,
    output cpu_pkg::fetch_entry_t head_o,
    output logic [CW-1:0]         count_o
);
    import cpu_pkg::*;

    localparam logic [CW-1:0] FULL_L = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] head_d;
    logic [PW-1:0] tail_q;
    logic [PW-1:0] tail_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Next pointer/occupancy values; flush clears everything at once.
    always_comb begin
        push_ok_s = push_i && (count_q != FULL_L);
        pop_ok_s  = pop_i && (count_q != {CW{1'b0}});
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush_i) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                tail_d = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_ok_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; a flushed push is never written.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!flush_i && push_ok_s) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, issues one-cycle-latency reads
// to instruction memory and buffers {pc, instr} pairs for the IF/ID stage.
// A read is only issued when the FIFO is guaranteed room for its return,
// so the returning data never needs to be stalled.
module fetch_queue #(
    parameter int                        DEPTH    = 4,
    parameter int                        ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                        DATA_W   = cpu_pkg::DATA_W,
    parameter logic [cpu_pkg::ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       imem_rd_en,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [DATA_W-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]     count
);
    import cpu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] fetch_pc_d;
    logic              inflight_q;
    logic              inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic [ADDR_W-1:0] inflight_pc_d;

    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic [CW:0]       occ_s;
    fetch_entry_t      push_entry_s;
    fetch_entry_t      head_s;
    logic [CW-1:0]     count_s;

    // Credit check, issue decision and next PC / in-flight tracking.
    always_comb begin
        pop_s  = out_valid && out_ready;
        push_s = inflight_q && !redirect_valid;
        // Occupancy after this cycle if nothing new is issued.
        occ_s  = {1'b0, count_s} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop_s};
        issue_s = !reset && !redirect_valid && (occ_s < DEPTH_L);
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
        end else if (issue_s) begin
            fetch_pc_d    = next_pc(fetch_pc_q);
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end else begin
            fetch_pc_d = fetch_pc_q;
            inflight_d = 1'b0;
        end
        push_entry_s.pc    = inflight_pc_q;
        push_entry_s.instr = imem_data;
    end

    // PC and in-flight read registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (count_s)
    );

    assign imem_rd_en = issue_s;
    assign imem_addr  = fetch_pc_q;
    assign out_valid  = (count_s != {CW{1'b0}});
    assign out_pc     = head_s.pc;
    assign out_instr  = head_s.instr;
    assign count      = count_s;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. Inputs change on the falling edge and
// outputs are sampled 1 ns later. Memory model returns 0xA000_0000 | addr
// one cycle after each read strobe.
module tb_fetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    logic        w_rd_en;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic [2:0]  w_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clock(clock), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .count(count)
    );

    fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFE)) u_wrap (
        .clock(clock), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_rd_en(w_rd_en), .imem_addr(w_addr), .imem_data(w_data),
        .out_valid(w_valid), .out_ready(out_ready), .out_pc(w_pc), .out_instr(w_instr),
        .count(w_count)
    );

    always @(posedge clock) begin
        if (imem_rd_en) imem_data <= 32'hA000_0000 | imem_addr;
        if (w_rd_en) w_data <= 32'hA000_0000 | w_addr;
    end

    // Ends at the falling edge that starts cycle 0 with reset released.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        @(negedge clock); #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rden got %b exp 0", imem_rd_en); end
        do_reset(); #1;
        checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL c0_issue got %b/%h exp 1/00000000", imem_rd_en, imem_addr); end
        @(negedge clock); #1;
        checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h1) begin errors++; $display("FAIL c1 got valid %b addr %h exp 0/00000001", out_valid, imem_addr); end
        @(negedge clock); #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hA000_0000) begin errors++; $display("FAIL c2_first got %b %h %h exp 1 00000000 a0000000", out_valid, out_pc, out_instr); end
        for (int k = 3; k <= 6; k++) begin
            @(negedge clock); #1;
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'(k - 2) || out_instr !== (32'hA000_0000 | 32'(k - 2)))
                begin errors++; $display("FAIL stream c%0d got %b %h %h exp pc %0d", k, out_valid, out_pc, out_instr, k - 2); end
        end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL steady_count got %0d exp 1", count); end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) @(negedge clock);
        out_ready = 1'b0;                   // cycle 3
        repeat (9) @(negedge clock); #1;    // cycle 12
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL stall_count got %0d exp 4", count); end
        checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rden got %b exp 0", imem_rd_en); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h1) begin errors++; $display("FAIL stall_head got %b %h exp 1 00000001", out_valid, out_pc); end
        @(negedge clock); out_ready = 1'b1; #1;   // cycle 13
        checks++; if (out_pc !== 32'h1 || count !== 3'd4 || imem_rd_en !== 1'b1) begin errors++; $display("FAIL release got pc %h cnt %0d rden %b exp 00000001 4 1", out_pc, count, imem_rd_en); end
        for (int p = 2; p <= 8; p++) begin
            @(negedge clock); #1;
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'(p)) begin errors++; $display("FAIL resume got %b %h exp 1 pc %0d", out_valid, out_pc, p); end
            if (p == 2) begin
                checks++; if (count !== 3'd3) begin errors++; $display("FAIL resume_count got %0d exp 3", count); end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (3) @(negedge clock);
        out_ready = 1'b0;                   // cycle 3
        repeat (2) @(negedge clock);        // cycle 5 = T
        redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        checks++; if (count !== 3'd3 || imem_rd_en !== 1'b0) begin errors++; $display("FAIL redir_T got cnt %0d rden %b exp 3 0", count, imem_rd_en); end
        @(negedge clock); redirect_valid = 1'b0; out_ready = 1'b1; #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL redir_T1 got cnt %0d valid %b exp 0 0", count, out_valid); end
        checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL redir_issue got %b %h exp 1 00000040", imem_rd_en, imem_addr); end
        @(negedge clock); #1;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL redir_T2 got valid %b cnt %0d exp 0 0", out_valid, count); end
        @(negedge clock); #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'hA000_0040) begin errors++; $display("FAIL redir_T3 got %b %h %h exp 1 00000040 a0000040", out_valid, out_pc, out_instr); end
        @(negedge clock); #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h41) begin errors++; $display("FAIL redir_T4 got %b %h exp 1 00000041", out_valid, out_pc); end
    endtask

    task automatic test_redirect_full();
        do_reset();
        repeat (3) @(negedge clock);
        out_ready = 1'b0;
        repeat (5) @(negedge clock);        // cycle 8
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_pre got %0d exp 4", count); end
        @(negedge clock); redirect_valid = 1'b0; #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL full_flush got cnt %0d valid %b exp 0 0", count, out_valid); end
        checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h80) begin errors++; $display("FAIL full_issue got %b %h exp 1 00000080", imem_rd_en, imem_addr); end
        repeat (2) @(negedge clock); #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h80) begin errors++; $display("FAIL full_T3 got %b %h exp 1 00000080", out_valid, out_pc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (4) @(negedge clock);        // cycle 4
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clock); redirect_pc = 32'h200; #1;
        checks++; if (count !== 3'd0 || imem_rd_en !== 1'b0) begin errors++; $display("FAIL b2b_mid got cnt %0d rden %b exp 0 0", count, imem_rd_en); end
        @(negedge clock); redirect_valid = 1'b0; #1;
        checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL b2b_issue got %b %h exp 1 00000200", imem_rd_en, imem_addr); end
        @(negedge clock); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_T2 got %b exp 0", out_valid); end
        @(negedge clock); #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin errors++; $display("FAIL b2b_T3 got %b %h exp 1 00000200", out_valid, out_pc); end
    endtask

    task automatic test_wrap();
        do_reset(); #1;
        checks++; if (w_addr !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_c0 got %h exp fffffffe", w_addr); end
        repeat (2) @(negedge clock); #1;
        checks++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_pc0 got %b %h exp 1 fffffffe", w_valid, w_pc); end
        @(negedge clock); #1;
        checks++; if (w_pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pc1 got %h exp ffffffff", w_pc); end
        @(negedge clock); #1;
        checks++; if (w_valid !== 1'b1 || w_pc !== 32'h0 || w_instr !== 32'hA000_0000) begin errors++; $display("FAIL wrap_pc2 got %b %h %h exp 1 00000000 a0000000", w_valid, w_pc, w_instr); end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) @(negedge clock);
        out_ready = 1'b0;
        @(negedge clock); #1;               // cycle 4
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL areset_pre got %0d exp 2", count); end
        #2 reset = 1'b1; #1;                // still before the next rising edge
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || imem_rd_en !== 1'b0) begin errors++; $display("FAIL areset_now got cnt %0d valid %b rden %b exp 0 0 0", count, out_valid, imem_rd_en); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL areset_pc got %h exp 00000000", imem_addr); end
        repeat (2) @(negedge clock);
        reset = 1'b0; out_ready = 1'b1; #1;
        checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL areset_c0 got %b %h exp 1 00000000", imem_rd_en, imem_addr); end
        repeat (2) @(negedge clock); #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL areset_c2 got %b %h exp 1 00000000", out_valid, out_pc); end
        @(negedge clock); #1;
        checks++; if (out_pc !== 32'h1) begin errors++; $display("FAIL areset_c3 got %h exp 00000001", out_pc); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_full();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end of the pipelined CPU. It owns the program counter, issues word-addressed reads to the synchronous instruction memory, and buffers the returned {pc, instruction} pairs in a small FIFO. It presents those pairs to the IF/ID buffer through a valid/ready handshake. It replaces the bare PC / PC-adder / PC-mux path, absorbs ID-stage stalls without re-fetching, and flushes cleanly on a branch or jump redirect resolved in WB.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_W, 32: PC and instruction-memory address width.
- DATA_W, 32: instruction width.
- RESET_PC, 0: fetch address after reset.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- redirect_valid  in  1  a taken branch or jump from WB (OR of bz/bn/jump terms).
- redirect_pc  in  ADDR_W  target; ALU result or data-memory output, already selected.
- imem_rd_en  out  1  read strobe to instruction memory.
- imem_addr  out  ADDR_W  word address.
- imem_data  in  DATA_W  read data; valid exactly one cycle after the read was issued.
- out_valid  out  1  head entry available.
- out_ready  in  1  IF/ID buffer accepts the head this cycle; low means stall.
- out_pc  out  ADDR_W  PC of the head instruction.
- out_instr  out  DATA_W  head instruction.
- count  out  $clog2(DEPTH)+1  current occupancy, for debug and coverage.

## Operation
- State: fetch_pc, inflight (1 bit), inflight_pc, FIFO storage, head and tail pointers, count.
- Issue:
  - imem_rd_en = !reset && !redirect_valid && (count + inflight − pop) < DEPTH.
  - imem_addr = fetch_pc.
  - On issue, fetch_pc <= fetch_pc + 1 (wraps modulo 2^ADDR_W), inflight <= 1 and inflight_pc <= fetch_pc. With no issue, inflight <= 0.
- Return: when inflight=1 and no redirect this cycle, push {inflight_pc, imem_data}. This credit rule guarantees a push never meets a full FIFO.
- Pop: out_valid && out_ready pops the head. out_valid = (count != 0). out_pc and out_instr are driven from the head and are don't-care when out_valid=0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Redirect has priority over everything. In a cycle with redirect_valid=1:
  - The FIFO is cleared (count <= 0, pointers <= 0).
  - The pop is ignored. out_valid may be high but the consumer must not rely on it.
  - An in-flight return arriving this cycle is discarded.
  - No issue occurs and inflight <= 0.
  - fetch_pc <= redirect_pc.
- Back-to-back redirects: the last one wins. Each one flushes again.
- Stall: with out_ready=0, the FIFO fills to DEPTH, then issue stops. No instruction is lost or duplicated.

## Timing
- Reset values: fetch_pc = RESET_PC, inflight = 0, count = 0, out_valid = 0, imem_rd_en = 0 while reset is high. Reset takes effect asynchronously mid-operation and discards all entries.
- Cycle 0 after reset deasserts: read issued for RESET_PC. Cycle 1: data pushed. Cycle 2: out_valid=1 with out_pc=RESET_PC.
- Redirect at cycle T: read for redirect_pc issued at T+1, out_valid at T+3. There is no bypass path.
- Steady state with out_ready=1: one instruction per cycle, consecutive PCs.
- All outputs except imem_rd_en and out_valid are registered or driven directly from registers. imem_rd_en is combinational on redirect_valid, out_ready, count and inflight.

## Structure
- Shared package cpu_pkg holds ADDR_W, DATA_W, RESET_PC and the fetch_entry_t struct {pc, instr}.
- One sub-module, fetch_fifo: a parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, count and head outputs. fetch_queue wraps it with the PC, in-flight tracking and credit logic.

## Test plan
- Reset release, out_ready=1, memory returns instr = 0xA000_0000 | addr: out sequence at pc 0, 1, 2, 3… with out_valid first high in cycle 2, one instruction per cycle.
- Stall: hold out_ready=0 from cycle 3 for 10 cycles: count saturates at 4 and imem_rd_en drops to 0. On release, PCs continue with no gap or duplicate.
- Redirect to 0x40 while count=3 and a read is in flight: count=0 next cycle, the stale return is dropped, out_valid rises at T+3 with out_pc=0x40, then 0x41.
- Redirect coinciding with out_ready=1 and the FIFO full: no pop is counted, the FIFO is flushed, fetch resumes at the target.
- Wrap-around: RESET_PC = 0xFFFF_FFFE: out_pc sequence 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Reset asserted mid-stream with count=2: outputs go to reset values immediately and not at a clock edge. After release, the sequence restarts at RESET_PC.
